// File: rtl/axi_wr_txn_arbiter_if.sv
// Bundle of requester-side and controller-side signals around axi_wr_txn_arbiter.
// The arbiter uses the slave modport; the master modport is the mirror view.
interface axi_wr_txn_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*4-1:0]          req_len;
  logic [NUM_REQ*2-1:0]          req_burst;
  logic [NUM_REQ*3-1:0]          req_size;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            req_done;
  logic [1:0]                    req_bresp;
  logic [3:0]                    req_bid;

  logic [ADDR_WIDTH-1:0]         awaddr_d;
  logic [3:0]                    TXN_ID_W_d;
  logic [1:0]                    awburst_d;
  logic [3:0]                    awlen_d;
  logic [2:0]                    awsize_d;
  logic [1:0]                    awlock_d;
  logic [1:0]                    awcache_d;
  logic [2:0]                    awprot_d;
  logic [DATA_WIDTH-1:0]         wdata_d;
  logic [STRB_WIDTH-1:0]         wstrb_d;
  logic                          wr_trn_en;
  logic [1:0]                    bresp_d;
  logic [3:0]                    bid_d;
  logic                          wr_rsp_en_d;
  logic                          busy;
  logic                          id_err;

  modport slave (
    input  req_valid, req_addr, req_len, req_burst, req_size, req_wdata, req_wstrb,
    input  bresp_d, bid_d, wr_rsp_en_d,
    output req_grant, req_done, req_bresp, req_bid,
    output awaddr_d, TXN_ID_W_d, awburst_d, awlen_d, awsize_d, awlock_d, awcache_d, awprot_d,
    output wdata_d, wstrb_d, wr_trn_en, busy, id_err
  );

  modport master (
    output req_valid, req_addr, req_len, req_burst, req_size, req_wdata, req_wstrb,
    output bresp_d, bid_d, wr_rsp_en_d,
    input  req_grant, req_done, req_bresp, req_bid,
    input  awaddr_d, TXN_ID_W_d, awburst_d, awlen_d, awsize_d, awlock_d, awcache_d, awprot_d,
    input  wdata_d, wstrb_d, wr_trn_en, busy, id_err
  );
endinterface

// File: rtl/axi_wr_txn_arbiter.sv
// Round-robin arbiter sharing one AXI write controller among NUM_REQ requesters.
// Optional response timeout enabled by defining WR_ARB_TIMEOUT_EN.
module axi_wr_txn_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                 AClk,
  input logic                 ARst,
  axi_wr_txn_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_err
    $error("axi_wr_txn_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]         rsp_bresp_q, rsp_bresp_d;
  logic [3:0]         rsp_bid_q, rsp_bid_d;
  logic               id_err_q, id_err_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               trn_en_q, trn_en_d;
  logic               busy_q, busy_d;
`ifdef WR_ARB_TIMEOUT_EN
  logic [15:0]        to_cnt_q, to_cnt_d;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // First pending requester at or above ptr, wrapping past NUM_REQ-1.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && vld[IDX_W'(idx)]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_ff @(posedge AClk) begin
    if (ARst) begin
      state_q     <= S_IDLE;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      rsp_bresp_q <= '0;
      rsp_bid_q   <= '0;
      id_err_q    <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      trn_en_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WR_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_bresp_q <= rsp_bresp_d;
      rsp_bid_q   <= rsp_bid_d;
      id_err_q    <= id_err_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      trn_en_q    <= trn_en_d;
      busy_q      <= busy_d;
`ifdef WR_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_bresp_d = rsp_bresp_q;
    rsp_bid_d   = rsp_bid_q;
    id_err_d    = id_err_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          gnt_idx_d = rr_pick(bus.req_valid, rr_ptr_q);
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // A real response beats a timeout landing in the same cycle.
        if (bus.wr_rsp_en_d) begin
          state_d   = S_DONE;
          rsp_bid_d = bus.bid_d;
          if (bus.bid_d != 4'(gnt_idx_q)) begin
            rsp_bresp_d = 2'b10;
            id_err_d    = 1'b1;
          end else begin
            rsp_bresp_d = bus.bresp_d;
          end
        end
`ifdef WR_ARB_TIMEOUT_EN
        else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          state_d     = S_DONE;
          rsp_bresp_d = 2'b10;
          rsp_bid_d   = 4'(gnt_idx_q);
        end
`endif
      end
      S_DONE: begin
        rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef WR_ARB_TIMEOUT_EN
  assign to_cnt_d = (state_q == S_WAIT) ? to_cnt_q + 16'd1 : 16'd0;
`endif

  // Registered outputs are computed from the upcoming state so they line up with it.
  always_comb begin
    grant_d  = '0;
    done_d   = '0;
    trn_en_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_LAUNCH: begin
        trn_en_d = 1'b1;
        grant_d  = onehot(gnt_idx_d);
      end
      S_WAIT:  grant_d = onehot(gnt_idx_d);
      S_DONE:  done_d  = onehot(gnt_idx_d);
      default: ;
    endcase
  end

  // The controller re-registers these every cycle, so keep them driven while busy.
  always_comb begin
    bus.awaddr_d   = '0;
    bus.TXN_ID_W_d = '0;
    bus.awburst_d  = '0;
    bus.awlen_d    = '0;
    bus.awsize_d   = '0;
    bus.wdata_d    = '0;
    bus.wstrb_d    = '0;
    if (state_q != S_IDLE) begin
      bus.awaddr_d   = bus.req_addr [int'(gnt_idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.TXN_ID_W_d = 4'(gnt_idx_q);
      bus.awburst_d  = bus.req_burst[int'(gnt_idx_q)*2 +: 2];
      bus.awlen_d    = bus.req_len  [int'(gnt_idx_q)*4 +: 4];
      bus.awsize_d   = bus.req_size [int'(gnt_idx_q)*3 +: 3];
      bus.wdata_d    = bus.req_wdata[int'(gnt_idx_q)*DATA_WIDTH +: DATA_WIDTH];
      bus.wstrb_d    = bus.req_wstrb[int'(gnt_idx_q)*STRB_WIDTH +: STRB_WIDTH];
    end
  end

  assign bus.awlock_d  = 2'b00;
  assign bus.awcache_d = 2'b00;
  assign bus.awprot_d  = 3'b000;
  assign bus.req_grant = grant_q;
  assign bus.req_done  = done_q;
  assign bus.req_bresp = rsp_bresp_q;
  assign bus.req_bid   = rsp_bid_q;
  assign bus.wr_trn_en = trn_en_q;
  assign bus.busy      = busy_q;
  assign bus.id_err    = id_err_q;

endmodule

// File: tb/tb_axi_wr_txn_arbiter.sv
// Directed bench for axi_wr_txn_arbiter: grant order, launch/response timing,
// ID mismatch, stray responses, dropped requests, reset mid-transaction.
module tb_axi_wr_txn_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 64;
  localparam int STRB_WIDTH  = 8;
  localparam int TIMEOUT_CYC = 8;

  logic AClk = 1'b0;
  logic ARst;
  int   errors = 0;
  int   checks = 0;

  axi_wr_txn_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
                          .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)) bus ();

  axi_wr_txn_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                       .STRB_WIDTH(STRB_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .AClk (AClk),
    .ARst (ARst),
    .bus  (bus)
  );

  always #5 AClk = ~AClk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] exp_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [3:0] exp_len(input int i);
    return 4'(i + 3);
  endfunction
  function automatic logic [63:0] exp_wdata(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 7)};
  endfunction
  function automatic logic [7:0] exp_strb(input int i);
    return 8'hFF >> i;
  endfunction
  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic tick();
    @(negedge AClk);
  endtask

  task automatic test_reset();
    ARst = 1'b1;
    tick();
    tick();
    checks++; if (bus.req_grant !== 4'b0) begin errors++; $display("FAIL rst_grant got=%b exp=0000", bus.req_grant); end
    checks++; if (bus.req_done !== 4'b0) begin errors++; $display("FAIL rst_done got=%b exp=0000", bus.req_done); end
    checks++; if (bus.wr_trn_en !== 1'b0) begin errors++; $display("FAIL rst_trn_en got=%b exp=0", bus.wr_trn_en); end
    checks++; if (bus.busy !== 1'b0 || bus.id_err !== 1'b0) begin errors++; $display("FAIL rst_busy_iderr got=%b%b exp=00", bus.busy, bus.id_err); end
    checks++; if (bus.awaddr_d !== 32'h0 || bus.wdata_d !== 64'h0 || bus.TXN_ID_W_d !== 4'h0) begin errors++; $display("FAIL rst_desc addr=%h data=%h id=%h exp=0", bus.awaddr_d, bus.wdata_d, bus.TXN_ID_W_d); end
    checks++; if (bus.req_bresp !== 2'b0 || bus.req_bid !== 4'h0) begin errors++; $display("FAIL rst_rsp bresp=%b bid=%h exp=0", bus.req_bresp, bus.req_bid); end
    ARst = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0100;
    tick();
    checks++; if (bus.wr_trn_en !== 1'b1 || bus.req_grant !== 4'b0100) begin errors++; $display("FAIL single_launch trn=%b grant=%b exp=1 0100", bus.wr_trn_en, bus.req_grant); end
    checks++; if (bus.TXN_ID_W_d !== 4'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_id id=%0d busy=%b exp=2 1", bus.TXN_ID_W_d, bus.busy); end
    checks++; if (bus.awaddr_d !== exp_addr(2) || bus.awlen_d !== exp_len(2) || bus.awsize_d !== 3'd3 || bus.awburst_d !== 2'b01) begin errors++; $display("FAIL single_desc addr=%h len=%h size=%h burst=%b", bus.awaddr_d, bus.awlen_d, bus.awsize_d, bus.awburst_d); end
    checks++; if (bus.wdata_d !== exp_wdata(2) || bus.wstrb_d !== exp_strb(2)) begin errors++; $display("FAIL single_data data=%h strb=%h exp=%h %h", bus.wdata_d, bus.wstrb_d, exp_wdata(2), exp_strb(2)); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.wr_trn_en !== 1'b0 || bus.req_grant !== 4'b0100 || bus.awaddr_d !== exp_addr(2)) begin errors++; $display("FAIL single_wait%0d trn=%b grant=%b addr=%h", c, bus.wr_trn_en, bus.req_grant, bus.awaddr_d); end
    end
    bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'd2; bus.bresp_d = 2'b00;
    tick();
    bus.wr_rsp_en_d = 1'b0; bus.req_valid = 4'b0;
    checks++; if (bus.req_done !== 4'b0100 || bus.req_bresp !== 2'b00 || bus.req_bid !== 4'd2) begin errors++; $display("FAIL single_done done=%b bresp=%b bid=%0d exp=0100 00 2", bus.req_done, bus.req_bresp, bus.req_bid); end
    checks++; if (bus.req_grant !== 4'b0) begin errors++; $display("FAIL single_done_grant got=%b exp=0000", bus.req_grant); end
    tick();
    checks++; if (bus.req_done !== 4'b0 || bus.busy !== 1'b0 || bus.awaddr_d !== 32'h0) begin errors++; $display("FAIL single_idle done=%b busy=%b addr=%h", bus.req_done, bus.busy, bus.awaddr_d); end
  endtask

  task automatic test_fairness();
    ARst = 1'b1;
    tick();
    ARst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus.wr_trn_en !== 1'b1 || bus.TXN_ID_W_d !== 4'(k % 4) || bus.req_grant !== oh(k % 4)) begin errors++; $display("FAIL fair_launch%0d trn=%b id=%0d grant=%b exp_id=%0d", k, bus.wr_trn_en, bus.TXN_ID_W_d, bus.req_grant, k % 4); end
      checks++; if (bus.awaddr_d !== exp_addr(k % 4) || bus.wstrb_d !== exp_strb(k % 4)) begin errors++; $display("FAIL fair_desc%0d addr=%h strb=%h", k, bus.awaddr_d, bus.wstrb_d); end
      tick();
      bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'(k % 4); bus.bresp_d = 2'(k);
      tick();
      bus.wr_rsp_en_d = 1'b0;
      checks++; if (bus.req_done !== oh(k % 4) || bus.req_bresp !== 2'(k)) begin errors++; $display("FAIL fair_done%0d done=%b bresp=%b exp=%b %b", k, bus.req_done, bus.req_bresp, oh(k % 4), 2'(k)); end
      if (k == 4) bus.req_valid = 4'b0;
      tick();
    end
  endtask

  task automatic test_id_mismatch();
    bus.req_valid = 4'b0010;
    tick();
    checks++; if (bus.TXN_ID_W_d !== 4'd1 || bus.wr_trn_en !== 1'b1) begin errors++; $display("FAIL idm_launch id=%0d trn=%b exp=1 1", bus.TXN_ID_W_d, bus.wr_trn_en); end
    tick();
    bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'd3; bus.bresp_d = 2'b00;
    tick();
    bus.wr_rsp_en_d = 1'b0; bus.req_valid = 4'b0;
    checks++; if (bus.req_done !== 4'b0010 || bus.req_bresp !== 2'b10) begin errors++; $display("FAIL idm_done done=%b bresp=%b exp=0010 10", bus.req_done, bus.req_bresp); end
    checks++; if (bus.id_err !== 1'b1) begin errors++; $display("FAIL idm_flag got=%b exp=1", bus.id_err); end
    tick();
    tick();
    checks++; if (bus.id_err !== 1'b1) begin errors++; $display("FAIL idm_sticky got=%b exp=1", bus.id_err); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 4'b0100;
    tick();
    checks++; if (bus.TXN_ID_W_d !== 4'd2) begin errors++; $display("FAIL rmid_launch id=%0d exp=2", bus.TXN_ID_W_d); end
    tick();
    ARst = 1'b1;
    tick();
    checks++; if (bus.req_grant !== 4'b0 || bus.req_done !== 4'b0 || bus.wr_trn_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_ctrl grant=%b done=%b trn=%b busy=%b exp=0", bus.req_grant, bus.req_done, bus.wr_trn_en, bus.busy); end
    checks++; if (bus.id_err !== 1'b0 || bus.req_bresp !== 2'b00) begin errors++; $display("FAIL rmid_rsp iderr=%b bresp=%b exp=0 00", bus.id_err, bus.req_bresp); end
    checks++; if (bus.awaddr_d !== 32'h0 || bus.wdata_d !== 64'h0 || bus.wstrb_d !== 8'h0 || bus.TXN_ID_W_d !== 4'h0) begin errors++; $display("FAIL rmid_desc addr=%h data=%h strb=%h id=%h exp=0", bus.awaddr_d, bus.wdata_d, bus.wstrb_d, bus.TXN_ID_W_d); end
    ARst = 1'b0;
    bus.req_valid = 4'b0101;
    tick();
    checks++; if (bus.wr_trn_en !== 1'b1 || bus.req_grant !== 4'b0001 || bus.TXN_ID_W_d !== 4'd0) begin errors++; $display("FAIL rmid_regrant trn=%b grant=%b id=%0d exp=1 0001 0", bus.wr_trn_en, bus.req_grant, bus.TXN_ID_W_d); end
    tick();
    bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'd0; bus.bresp_d = 2'b00;
    tick();
    bus.wr_rsp_en_d = 1'b0; bus.req_valid = 4'b0;
    checks++; if (bus.req_done !== 4'b0001) begin errors++; $display("FAIL rmid_done got=%b exp=0001", bus.req_done); end
    tick();
  endtask

  task automatic test_stray_and_drop();
    bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'd1; bus.bresp_d = 2'b01;
    tick();
    bus.wr_rsp_en_d = 1'b0;
    checks++; if (bus.req_done !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stray_done done=%b busy=%b exp=0000 0", bus.req_done, bus.busy); end
    tick();
    checks++; if (bus.req_done !== 4'b0) begin errors++; $display("FAIL stray_late got=%b exp=0000", bus.req_done); end
    bus.req_valid = 4'b1000;
    tick();
    checks++; if (bus.TXN_ID_W_d !== 4'd3 || bus.wr_trn_en !== 1'b1) begin errors++; $display("FAIL drop_launch id=%0d trn=%b exp=3 1", bus.TXN_ID_W_d, bus.wr_trn_en); end
    bus.req_valid = 4'b0;
    tick();
    tick();
    checks++; if (bus.req_grant !== 4'b1000 || bus.busy !== 1'b1) begin errors++; $display("FAIL drop_hold grant=%b busy=%b exp=1000 1", bus.req_grant, bus.busy); end
    bus.wr_rsp_en_d = 1'b1; bus.bid_d = 4'd3; bus.bresp_d = 2'b01;
    tick();
    bus.wr_rsp_en_d = 1'b0;
    checks++; if (bus.req_done !== 4'b1000 || bus.req_bresp !== 2'b01 || bus.req_bid !== 4'd3) begin errors++; $display("FAIL drop_done done=%b bresp=%b bid=%0d exp=1000 01 3", bus.req_done, bus.req_bresp, bus.req_bid); end
    tick();
    tick();
    checks++; if (bus.wr_trn_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL drop_idle trn=%b busy=%b exp=0 0", bus.wr_trn_en, bus.busy); end
  endtask

`ifdef WR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req_valid = 4'b0010;
    tick();
    checks++; if (bus.wr_trn_en !== 1'b1 || bus.TXN_ID_W_d !== 4'd1) begin errors++; $display("FAIL to_launch trn=%b id=%0d exp=1 1", bus.wr_trn_en, bus.TXN_ID_W_d); end
    bus.req_valid = 4'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (bus.req_done !== 4'b0) begin errors++; $display("FAIL to_early%0d got=%b exp=0000", c, bus.req_done); end
    end
    tick();
    checks++; if (bus.req_done !== 4'b0010 || bus.req_bresp !== 2'b10 || bus.req_bid !== 4'd1) begin errors++; $display("FAIL to_done done=%b bresp=%b bid=%0d exp=0010 10 1", bus.req_done, bus.req_bresp, bus.req_bid); end
    tick();
  endtask
`endif

  initial begin
    ARst            = 1'b1;
    bus.req_valid   = '0;
    bus.wr_rsp_en_d = 1'b0;
    bus.bresp_d     = '0;
    bus.bid_d       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr [i*ADDR_WIDTH +: ADDR_WIDTH] = exp_addr(i);
      bus.req_len  [i*4 +: 4]                   = exp_len(i);
      bus.req_burst[i*2 +: 2]                   = 2'b01;
      bus.req_size [i*3 +: 3]                   = 3'd3;
      bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = exp_wdata(i);
      bus.req_wstrb[i*STRB_WIDTH +: STRB_WIDTH] = exp_strb(i);
    end
    test_reset();
    test_single();
    test_fairness();
    test_id_mismatch();
    test_reset_mid();
    test_stray_and_drop();
`ifdef WR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
